// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the nibble-serial CLA word sequencer.
//   NIBBLE_W : width of one pass through the shared carry-look-ahead adder
//   state_t  : sequencer FSM encoding (2'd3 is unused and recovers to IDLE)
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_word_sequencer_cla.sv
// -----------------------------------------------------------------------------
// carry_look_ahead
// 4-bit carry-look-ahead adder, purely combinational.
// Ports:
//   a_in, b_in [3:0] : operands
//   c_in             : carry into bit 0
//   sum_out [3:0]    : a_in + b_in + c_in, low 4 bits
//   carry_out        : carry out of bit 3
// -----------------------------------------------------------------------------
module carry_look_ahead (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [3:0] sum_out,
    output logic       carry_out
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a_in & b_in;
    assign w_p = a_in ^ b_in;

    // All carries expanded from c_in so no carry ripples between bits.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

    assign sum_out   = w_p ^ w_c[3:0];
    assign carry_out = w_c[4];

endmodule

// File: rtl/cla_word_sequencer.sv
// -----------------------------------------------------------------------------
// cla_word_sequencer
// Wide adder that time-shares one 4-bit carry-look-ahead adder over WIDTH/4
// nibbles, LS nibble first, with the carry registered between passes.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | ready_out=1, waiting for valid_in; operands captured on accept
//   RUN     | one nibble per cycle through the CLA, carry held in r_carry
//   DONE    | valid_out=1, result held until ready_in
//
// Ports:
//   clk_in, rst_in        : clock (rising edge), synchronous active-high reset
//   a_in, b_in, c_in      : operands and carry-in, sampled only on accept
//   valid_in / ready_out  : request handshake
//   sum_out, carry_out    : registered result
//   valid_out / ready_in  : result handshake
// -----------------------------------------------------------------------------
module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("cla_word_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_carry;
    logic                 r_carry_out;
    logic [IDX_W-1:0]     r_idx;

    logic [NIBBLE_W-1:0]  w_a_nib;
    logic [NIBBLE_W-1:0]  w_b_nib;
    logic [NIBBLE_W-1:0]  w_cla_sum;
    logic                 w_cla_carry;
    logic                 w_accept;
    logic                 w_last;

    assign ready_out = (r_state == ST_IDLE);
    assign valid_out = (r_state == ST_DONE);
    assign sum_out   = r_sum;
    assign carry_out = r_carry_out;

    assign w_accept  = valid_in && ready_out;
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));

    // Nibble select written as a constant-index mux so no select can reach
    // past the operand, even for the single-nibble configuration.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    carry_look_ahead u_cla (
        .a_in      (w_a_nib),
        .b_in      (w_b_nib),
        .c_in      (r_carry),
        .sum_out   (w_cla_sum),
        .carry_out (w_cla_carry)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_RUN;
            ST_RUN:  if (w_last)   w_next = ST_DONE;
            ST_DONE: if (ready_in) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a         <= a_in;
                        r_b         <= b_in;
                        r_carry     <= c_in;
                        r_sum       <= '0;
                        r_carry_out <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                ST_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IDX_W'(n)) begin
                            r_sum[n*NIBBLE_W +: NIBBLE_W] <= w_cla_sum;
                        end
                    end
                    r_carry <= w_cla_carry;
                    // Final carry gets its own register so carry_out only
                    // ever shows a completed result.
                    if (w_last) begin
                        r_carry_out <= w_cla_carry;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
